// File: rtl/parity_serializer.sv
// rtl/parity_serializer.sv - parallel word to LSB-first serial frame with trailing parity bit
//
// Accepts a DATA_WIDTH-bit word on a valid/ready handshake and emits it as
// DATA_WIDTH data bits (LSB first) followed by one parity bit, one bit per
// cycle. A new word may be accepted during the parity cycle, so frames can
// run back to back with no idle gap.
//
// Ports:
//   clk        - rising-edge clock
//   rstn       - synchronous active-low reset
//   din        - parallel word to transmit
//   din_valid  - din holds a word offered for transfer
//   din_ready  - a word can be accepted this cycle (IDLE or PARITY)
//   sout       - serial frame bit (registered)
//   sout_valid - sout carries a frame bit (registered)
//   sout_last  - sout carries the parity bit (registered)

module parity_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  sout_last
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic ODD_SEL = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_par;
  logic                  w_par_nxt;
  logic                  r_sout;
  logic                  w_sout_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic                  w_accept;

  assign din_ready  = (r_state != SHIFT);
  assign w_accept   = din_valid && din_ready;
  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign sout_last  = r_last;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_sout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;

    case (r_state)
      IDLE, PARITY: begin
        if (w_accept) begin
          // Bit 0 goes straight to the output flop; the shift register keeps
          // the remaining bits so the frame never depends on din again.
          w_state_nxt = SHIFT;
          w_shreg_nxt = din >> 1;
          w_cnt_nxt   = '0;
          w_par_nxt   = (^din) ^ ODD_SEL;
          w_sout_nxt  = din[0];
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        w_valid_nxt = 1'b1;
        // r_cnt indexes the data bit currently on sout.
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = PARITY;
          w_sout_nxt  = r_par;
          w_last_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_sout_nxt  = r_shreg[0];
          w_shreg_nxt = r_shreg >> 1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_par   <= w_par_nxt;
      r_sout  <= w_sout_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: doc/parity_serializer.md
PARITY_SERIALIZER -- requirements
Module: parity_serializer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the parallel word width (legal range 2..32).
REQ-002 The module SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-004 The module SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port din  input  DATA_WIDTH  parallel word to transmit.
REQ-006 The module SHALL have port din_valid  input  1  din holds a word offered for transfer.
REQ-007 The module SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-008 The module SHALL have port sout  output  1  serial bit stream to the downstream parity checker.
REQ-009 The module SHALL have port sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 The module SHALL have port sout_last  output  1  sout carries the parity bit (final bit of frame) this cycle.

Function
REQ-011 The module SHALL implement states IDLE, SHIFT, PARITY.
REQ-012 The module SHALL treat a word as accepted on a rising edge where din_valid=1 and din_ready=1, and SHALL capture din into an internal shift register at that edge.
REQ-013 The module SHALL drive din_ready=1 in IDLE and in PARITY, and din_ready=0 in SHIFT.
REQ-014 The module SHALL ignore din_valid while din_ready=0: no capture and no state change; upstream holds din/din_valid.
REQ-015 The module SHALL register sout, sout_valid and sout_last; all three SHALL be driven from flops, not combinationally from inputs.
REQ-016 The module SHALL, for a word accepted at edge N, present data bit 0 on sout in the cycle after edge N, with sout_valid=1 (latency 1 cycle).
REQ-017 The module SHALL emit each frame as DATA_WIDTH data bits LSB first, one per cycle, followed by one parity bit: a DATA_WIDTH+1 cycle frame.
REQ-018 The module SHALL compute the parity bit as XOR of the captured word when PARITY_ODD=0, and its inverse when PARITY_ODD=1, so the frame holds an even (resp. odd) count of ones.
REQ-019 The module SHALL use a bit counter of width $clog2(DATA_WIDTH) that counts 0..DATA_WIDTH-1 in SHIFT and SHALL move to PARITY after bit DATA_WIDTH-1.
REQ-020 The module SHALL assert sout_last=1 only in the parity-bit cycle, together with sout_valid=1.
REQ-021 The module SHALL, when a word is accepted in PARITY, enter SHIFT and output bit 0 of the new word in the next cycle: back-to-back frames with zero gap.
REQ-022 The module SHALL, when no word is accepted in PARITY, return to IDLE and drive sout=0, sout_valid=0, sout_last=0 in the next cycle.
REQ-023 The module SHALL hold sout=0, sout_valid=0 and sout_last=0 in IDLE while no word is accepted.
REQ-024 The module SHALL not be affected by changes on din after acceptance; the frame comes only from the captured copy.

Reset
REQ-025 The module SHALL, on a rising edge with rstn=0, go to IDLE, clear the bit counter and shift register, and drive sout=0, sout_valid=0, sout_last=0, din_ready=1 from the next cycle.
REQ-026 The module SHALL treat rstn=0 mid-frame as an abort: the partial frame is discarded, no parity bit is sent, and no word is accepted on that edge even if din_valid=1.
REQ-027 The module SHALL accept a new word on the first edge with rstn=1 and din_valid=1.

Verification
REQ-028 The bench SHALL cover: DATA_WIDTH=8, PARITY_ODD=0, din=8'hA5 one-cycle handshake -> sout 1,0,1,0,0,1,0,1 then parity 0; sout_valid high 9 cycles; sout_last high on 9th only.
REQ-029 The bench SHALL cover: din=8'h07, PARITY_ODD=0 -> parity bit 1; same word with PARITY_ODD=1 -> parity bit 0; din=8'h00 even -> 9 zero bits, parity 0.
REQ-030 The bench SHALL cover: din_valid held high with 8'h3C then 8'hFF -> 18 consecutive sout_valid cycles, no gap; sout_last in cycles 9 and 18; second parity bit 0.
REQ-031 The bench SHALL cover: din_valid raised with a different word during SHIFT -> din_ready=0, word not captured, current frame unchanged; word accepted in the PARITY cycle.
REQ-032 The bench SHALL cover: rstn=0 for one edge during data bit 4 -> next cycle sout_valid=0, sout_last=0, din_ready=1; no parity bit seen.
REQ-033 The bench SHALL cover: end-to-end with the downstream parity checker on 16 random words -> checker reports even parity at every sout_last.
